ahb_periph_subsystem: RTL and testbench



---
 rtl/ahb_periph_subsystem.sv | 226 ++++++++++++++++++++++
 tb/tb_ahb_periph_subsystem.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_periph_subsystem.sv
// AHB-Lite peripheral tile: 16-word register file plus timer/watchdog/PWM block.
// Define AHB_PWM_EN to build the PWM mode, thres register and pwm output.
module ahb_periph_subsystem #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_FILE_DEPTH = 16
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [3:0]            HPROT,
  input  logic [2:0]            HBURST,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  output logic                  HREADY,
  output logic                  HRESP,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  pwm,
  output logic                  wd_rst
);

  localparam int IDX_W = $clog2(REG_FILE_DEPTH);
  localparam int OFF_W = (IDX_W > 5) ? IDX_W : 5;
  localparam int LOW_W = ADDR_WIDTH - 2;

  // state   | meaning
  // ST_OK   | idle or zero-wait OKAY data phase
  // ST_ERR1 | first ERROR cycle, HREADY low
  // ST_ERR2 | second ERROR cycle, HREADY high
  typedef enum logic [1:0] {ST_OK, ST_ERR1, ST_ERR2} resp_state_e;

  resp_state_e state_q, state_d;

  logic [1:0] rst_hold_q;
  logic       core_rst;
  logic       sync_rst;

  logic                  unused_in;
  logic [1:0]            region;
  logic [LOW_W-1:0]      low;
  logic                  xfer, rf_hit, tmr_hit, addr_err;
  logic                  dp_valid_q, dp_valid_d, dp_write_q, dp_write_d, dp_tmr_q, dp_tmr_d;
  logic [OFF_W-1:0]      dp_off_q, dp_off_d;
  logic                  wr_en, rf_we, wr_ctrl, wr_load;
  logic [DATA_WIDTH-1:0] rf_q [REG_FILE_DEPTH];
  logic [2:0]            ctrl_q, ctrl_d;
  logic [DATA_WIDTH-1:0] load_q, load_d, count_q, count_d, count_rd, rdata;
  logic                  status_q, status_d, wd_rst_q, wd_rst_d;
  logic                  mode_pwm, mode_wd, mode_tmr;
`ifdef AHB_PWM_EN
  logic                  wr_thres;
  logic [DATA_WIDTH-1:0] thres_q, thres_d, pwm_cnt_q, pwm_cnt_d;
`endif

  assign unused_in = ^{HPROT, HBURST, HTRANS[0]};

  // Internal reset is released two edges after HRESET falls.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) rst_hold_q <= 2'b11;
    else        rst_hold_q <= {rst_hold_q[0], 1'b0};
  end
  assign core_rst = rst_hold_q[1];
  assign sync_rst = ~rst_hold_q[1];

  always_comb begin
    region  = HADDR[ADDR_WIDTH-1 -: 2];
    low     = HADDR[LOW_W-1:0];
    xfer    = HREADY && HTRANS[1];
    rf_hit  = (region == 2'b00) && (low < LOW_W'(REG_FILE_DEPTH));
    tmr_hit = (region == 2'b01) &&
              ((low == LOW_W'(32'h00)) || (low == LOW_W'(32'h04)) || (low == LOW_W'(32'h0C)) ||
               (low == LOW_W'(32'h10)) || (low == LOW_W'(32'h14)));
    addr_err   = xfer && !((HSIZE <= 3'd2) && (rf_hit || tmr_hit));
    dp_valid_d = xfer && !addr_err;
    dp_write_d = HWRITE;
    dp_tmr_d   = region[0];
    dp_off_d   = HADDR[OFF_W-1:0];
  end

  always_comb begin
    state_d = ST_OK;
    HREADY  = 1'b1;
    HRESP   = 1'b0;
    case (state_q)
      ST_ERR1: begin
        state_d = ST_ERR2;
        HREADY  = 1'b0;
        HRESP   = 1'b1;
      end
      ST_ERR2: begin
        HRESP   = 1'b1;
        state_d = addr_err ? ST_ERR1 : ST_OK;
      end
      default: state_d = addr_err ? ST_ERR1 : ST_OK;
    endcase
  end

  always_ff @(posedge HCLK or posedge core_rst) begin
    if (core_rst) begin
      state_q    <= ST_OK;
      dp_valid_q <= 1'b0;
      dp_write_q <= 1'b0;
      dp_tmr_q   <= 1'b0;
      dp_off_q   <= '0;
    end else begin
      state_q    <= state_d;
      dp_valid_q <= dp_valid_d;
      dp_write_q <= dp_write_d;
      dp_tmr_q   <= dp_tmr_d;
      dp_off_q   <= dp_off_d;
    end
  end

  assign wr_en   = dp_valid_q && dp_write_q;
  assign rf_we   = wr_en && !dp_tmr_q;
  assign wr_ctrl = wr_en && dp_tmr_q && (dp_off_q[4:0] == 5'h00);
  assign wr_load = wr_en && dp_tmr_q && (dp_off_q[4:0] == 5'h04);

  always_ff @(posedge HCLK or posedge core_rst) begin
    if (core_rst) begin
      for (int i = 0; i < REG_FILE_DEPTH; i++) rf_q[i] <= '0;
    end else if (rf_we) begin
      rf_q[dp_off_q[IDX_W-1:0]] <= HWDATA;
    end
  end

`ifdef AHB_PWM_EN
  assign wr_thres = wr_en && dp_tmr_q && (dp_off_q[4:0] == 5'h0C);
  assign mode_pwm = ctrl_q[2];
`else
  assign mode_pwm = 1'b0;
`endif
  assign mode_wd  = !mode_pwm && ctrl_q[1];
  assign mode_tmr = !mode_pwm && !ctrl_q[1] && ctrl_q[0];

  always_comb begin
    ctrl_d   = ctrl_q;
    load_d   = load_q;
    count_d  = count_q;
    status_d = status_q;
    wd_rst_d = wd_rst_q;
`ifdef AHB_PWM_EN
    thres_d   = thres_q;
    pwm_cnt_d = pwm_cnt_q;
    if (wr_thres) thres_d = HWDATA;
`endif
    if (wr_ctrl) ctrl_d = HWDATA[2:0];
    if (wr_load) load_d = HWDATA;
    if (wr_ctrl || wr_load) begin
      count_d  = load_d;
      status_d = 1'b0;
`ifdef AHB_PWM_EN
      pwm_cnt_d = '0;
`endif
    end else if (mode_pwm) begin
`ifdef AHB_PWM_EN
      pwm_cnt_d = (({1'b0, pwm_cnt_q} + (DATA_WIDTH+1)'(1)) >= {1'b0, load_q}) ? '0
                                                                               : pwm_cnt_q + DATA_WIDTH'(1);
`endif
    end else if (mode_wd) begin
      if (count_q != '0) count_d  = count_q - DATA_WIDTH'(1);
      else               wd_rst_d = 1'b1;
    end else if (mode_tmr) begin
      if (count_q != '0)             count_d  = count_q - DATA_WIDTH'(1);
      if (count_q <= DATA_WIDTH'(1)) status_d = 1'b1;
    end
  end

  always_ff @(posedge HCLK or posedge core_rst) begin
    if (core_rst) begin
      ctrl_q   <= '0;
      load_q   <= DATA_WIDTH'(32'h10);
      count_q  <= '0;
      status_q <= 1'b0;
      wd_rst_q <= 1'b0;
`ifdef AHB_PWM_EN
      thres_q   <= '0;
      pwm_cnt_q <= '0;
`endif
    end else begin
      ctrl_q   <= ctrl_d;
      load_q   <= load_d;
      count_q  <= count_d;
      status_q <= status_d;
      wd_rst_q <= wd_rst_d;
`ifdef AHB_PWM_EN
      thres_q   <= thres_d;
      pwm_cnt_q <= pwm_cnt_d;
`endif
    end
  end

`ifdef AHB_PWM_EN
  assign count_rd = mode_pwm ? pwm_cnt_q : count_q;
  assign pwm      = mode_pwm && (pwm_cnt_q < thres_q);
`else
  assign count_rd = count_q;
  assign pwm      = 1'b0;
`endif

  always_comb begin
    rdata = '0;
    if (dp_valid_q && !dp_write_q) begin
      if (!dp_tmr_q) begin
        rdata = rf_q[dp_off_q[IDX_W-1:0]];
      end else begin
        case (dp_off_q[4:0])
          5'h00:   rdata = DATA_WIDTH'(ctrl_q);
          5'h04:   rdata = load_q;
`ifdef AHB_PWM_EN
          5'h0C:   rdata = thres_q;
`endif
          5'h10:   rdata = count_rd;
          5'h14:   rdata = DATA_WIDTH'(status_q);
          default: rdata = '0;
        endcase
      end
    end
  end

  assign HRDATA = rdata;
  assign wd_rst = wd_rst_q;

endmodule

// File: tb/tb_ahb_periph_subsystem.sv
// Directed self-checking bench for ahb_periph_subsystem.
module tb_ahb_periph_subsystem;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [3:0]  HPROT;
  logic [2:0]  HBURST;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HRESP;
  logic [31:0] HRDATA;
  logic        pwm;
  logic        wd_rst;

  int checks = 0;
  int errors = 0;

  logic [31:0] ba [4];
  logic [31:0] bd [4];

  ahb_periph_subsystem dut (
    .HCLK(HCLK), .HRESET(HRESET), .HWRITE(HWRITE), .HSIZE(HSIZE), .HPROT(HPROT),
    .HBURST(HBURST), .HADDR(HADDR), .HTRANS(HTRANS), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA), .pwm(pwm), .wd_rst(wd_rst)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Single transfer started at posedge+1; returns read data, ERROR flag, HREADY-low cycles.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [2:0] sz, output logic [31:0] rd, output logic rsp, output int nw);
    HTRANS = 2'b10; HADDR = addr; HWRITE = wr; HSIZE = sz;
    @(posedge HCLK); #1;
    HTRANS = 2'b00; HWDATA = wd; HWRITE = 1'b0;
    rsp = 1'b0; nw = 0; rd = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge HCLK);
      rd  = HRDATA;
      rsp = rsp | HRESP;
      if (HREADY) break;
      nw++;
    end
    @(posedge HCLK); #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] rd; logic rsp; int nw;
    xfer(1'b1, a, d, 3'd2, rd, rsp, nw);
    chk($sformatf("write @%08h okay (waits*2+resp)", a), 32'(nw) * 2 + 32'(rsp), 32'd0);
  endtask

  task automatic rd_raw(input logic [31:0] a, output logic [31:0] v);
    logic rsp; int nw;
    xfer(1'b0, a, 32'd0, 3'd2, v, rsp, nw);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] rd; logic rsp; int nw;
    xfer(1'b0, a, 32'd0, 3'd2, rd, rsp, nw);
    chk(tag, rd, exp);
    chk({tag, " okay"}, 32'(nw) * 2 + 32'(rsp), 32'd0);
  endtask

  task automatic err_chk(input string tag, input logic w, input logic [31:0] a, input logic [2:0] sz);
    logic [31:0] rd; logic rsp; int nw;
    xfer(w, a, 32'hFF, sz, rd, rsp, nw);
    chk({tag, " resp"}, 32'(rsp), 32'd1);
    chk({tag, " hready-low cycles"}, 32'(nw), 32'd1);
  endtask

  task automatic burst4(input logic [2:0] hb);
    HWRITE = 1'b1; HSIZE = 3'd2; HBURST = hb;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        HTRANS = (i == 0) ? 2'b10 : 2'b11;
        HADDR  = ba[i];
      end else begin
        HTRANS = 2'b00;
        HWRITE = 1'b0;
      end
      if (i > 0) HWDATA = bd[i-1];
      @(negedge HCLK);
      chk($sformatf("burst beat %0d ready/resp", i), {30'd0, HREADY, HRESP}, 32'h2);
      @(posedge HCLK); #1;
    end
    HBURST = 3'd0;
  endtask

  task automatic do_reset();
    @(posedge HCLK); #1;
    HRESET = 1'b1;
    #1;
    chk("reset async wd_rst", 32'(wd_rst), 32'd0);
    chk("reset sync_rst low", 32'(dut.sync_rst), 32'd0);
    repeat (2) @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    @(negedge HCLK);
    chk("sync_rst after 0 edges", 32'(dut.sync_rst), 32'd0);
    @(negedge HCLK);
    chk("sync_rst after 1 edge", 32'(dut.sync_rst), 32'd0);
    @(negedge HCLK);
    chk("sync_rst after 2 edges", 32'(dut.sync_rst), 32'd1);
    @(posedge HCLK); #1;
  endtask

  initial begin
    logic [31:0] v;
    logic        done;
    int          highs;

    HRESET = 1'b1; HWRITE = 1'b0; HSIZE = 3'd2; HPROT = 4'h3; HBURST = 3'd0;
    HADDR = '0; HTRANS = 2'b00; HWDATA = '0;
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    chk("reset HREADY", 32'(HREADY), 32'd1);
    chk("reset HRESP", 32'(HRESP), 32'd0);
    chk("reset HRDATA", HRDATA, 32'd0);
    chk("reset pwm", 32'(pwm), 32'd0);
    chk("reset wd_rst", 32'(wd_rst), 32'd0);
    do_reset();

    rd_chk("reset ctrl", 32'h4000_0000, 32'h0);
    rd_chk("reset load", 32'h4000_0004, 32'h10);
    rd_chk("reset thres", 32'h4000_000C, 32'h0);
    rd_chk("reset count", 32'h4000_0010, 32'h0);
    rd_chk("reset status", 32'h4000_0014, 32'h0);
    rd_chk("reset rf[3]", 32'h0000_0003, 32'h0);

    // NONSEQ @0x00, BUSY beat pointing at 0x05, then SEQ @0x0F
    HTRANS = 2'b10; HADDR = 32'h00; HWRITE = 1'b1; HSIZE = 3'd2;
    @(posedge HCLK); #1;
    HTRANS = 2'b01; HADDR = 32'h05; HWDATA = 32'h0A;
    @(posedge HCLK); #1;
    HTRANS = 2'b11; HADDR = 32'h0F; HWDATA = 32'hDEAD;
    @(posedge HCLK); #1;
    HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = 32'h04;
    @(posedge HCLK); #1;
    rd_chk("rf[0] after busy seq", 32'h00, 32'h0A);
    rd_chk("rf[15] after busy seq", 32'h0F, 32'h04);
    rd_chk("rf[5] untouched by busy", 32'h05, 32'h0);

    ba = '{32'h01, 32'h02, 32'h03, 32'h04};
    bd = '{32'h23, 32'h12, 32'h34, 32'h56};
    burst4(3'd1);
    ba = '{32'h00, 32'h04, 32'h08, 32'h0C};
    bd = '{32'h1, 32'h2, 32'h3, 32'h4};
    burst4(3'd3);
    rd_chk("rf[0]", 32'h00, 32'h1);
    rd_chk("rf[1]", 32'h01, 32'h23);
    rd_chk("rf[2]", 32'h02, 32'h12);
    rd_chk("rf[3]", 32'h03, 32'h34);
    rd_chk("rf[4]", 32'h04, 32'h2);
    rd_chk("rf[8]", 32'h08, 32'h3);
    rd_chk("rf[12]", 32'h0C, 32'h4);
    rd_chk("rf[15]", 32'h0F, 32'h04);

    err_chk("rf index 32", 1'b1, 32'h20, 3'd2);
    rd_chk("rf[0] unchanged after error", 32'h00, 32'h1);
    err_chk("region 10", 1'b0, 32'h8000_0000, 3'd2);
    err_chk("region 11", 1'b1, 32'hC000_0001, 3'd2);
    err_chk("hsize dword", 1'b1, 32'h01, 3'd3);
    rd_chk("rf[1] unchanged after hsize error", 32'h01, 32'h23);
    err_chk("timer offset 0x08", 1'b0, 32'h4000_0008, 3'd2);
    err_chk("timer offset 0x18", 1'b1, 32'h4000_0018, 3'd2);

    wr(32'h4000_0010, 32'h99);
    rd_chk("count ignores RO write", 32'h4000_0010, 32'h0);
    wr(32'h4000_0014, 32'h1);
    rd_chk("status ignores RO write", 32'h4000_0014, 32'h0);

    // Normal timer: count = 5 at load commit, one decrement before the next read samples
    wr(32'h4000_0000, 32'h1);
    wr(32'h4000_0004, 32'h5);
    rd_chk("timer count after 1 cycle", 32'h4000_0010, 32'h4);
    rd_chk("timer not done early", 32'h4000_0014, 32'h0);
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      rd_raw(32'h4000_0014, v);
      done = v[0];
    end
    chk("timer done reached", 32'(done), 32'd1);
    rd_chk("timer count at 0", 32'h4000_0010, 32'h0);
    rd_chk("timer status sticky", 32'h4000_0014, 32'h1);

    // Watchdog with a kick: fires 6 edges after the final load write commits
    wr(32'h4000_0000, 32'h2);
    wr(32'h4000_0004, 32'h5);
    repeat (6) @(negedge HCLK);
    chk("wd not fired before 6 edges", 32'(wd_rst), 32'd0);
    @(negedge HCLK);
    chk("wd fired at 6 edges", 32'(wd_rst), 32'd1);
    @(posedge HCLK); #1;
    wr(32'h4000_0000, 32'h0);
    repeat (5) @(negedge HCLK);
    chk("wd_rst sticky", 32'(wd_rst), 32'd1);
    do_reset();
    rd_chk("rf[0] after reset", 32'h00, 32'h0);
    rd_chk("load after reset", 32'h4000_0004, 32'h10);

    wr(32'h4000_0004, 32'h0);
    wr(32'h4000_0000, 32'h2);
    @(negedge HCLK);
    chk("wd load=0 before edge", 32'(wd_rst), 32'd0);
    @(negedge HCLK);
    chk("wd load=0 next cycle", 32'(wd_rst), 32'd1);
    do_reset();

    wr(32'h4000_000C, 32'h2);
    wr(32'h4000_0000, 32'h4);
    highs = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge HCLK);
      if (pwm) highs++;
    end
    @(posedge HCLK); #1;
`ifdef AHB_PWM_EN
    chk("pwm highs thres=2 load=16", 32'(highs), 32'd4);
    rd_chk("thres readback", 32'h4000_000C, 32'h2);
    wr(32'h4000_000C, 32'h20);
    highs = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge HCLK);
      if (pwm) highs++;
    end
    @(posedge HCLK); #1;
    chk("pwm highs thres>=load", 32'(highs), 32'd32);
    wr(32'h4000_000C, 32'h0);
    highs = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge HCLK);
      if (pwm) highs++;
    end
    @(posedge HCLK); #1;
    chk("pwm highs thres=0", 32'(highs), 32'd0);
`else
    chk("pwm tied low", 32'(highs), 32'd0);
    rd_chk("thres reads 0", 32'h4000_000C, 32'h0);
    rd_chk("count holds with bit2 only", 32'h4000_0010, 32'h10);
    rd_chk("ctrl bit2 stored", 32'h4000_0000, 32'h4);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
